posit_decoder_pipe: RTL
=======================

// Module: posit_decoder_pipe
// PURPOSE
//  Parametrised, pipelined posit decoder for posit<N,ES>. Takes a raw posit word and
//  returns its decoded fields: sign, signed regime k, exponent, fraction, and zero/NaR
//  flags. Three register stages with valid/ready backpressure on both sides, plus a
//  sideband tag carried alongside each word. Sits between the operand buffers and the
//  posit arithmetic units, replacing the fixed-width combinational 64-bit/ES=4 decoder.
// PARAMETERS
//  N      32             posit word width; legal range 8..64
//  ES     2              exponent field width; legal range 0..4, with ES <= N-3
//  TAG_W  4              sideband tag width, passed through unchanged; legal minimum 1
//  RS     $clog2(N)+1    localparam: signed regime width
//  FS     N-3-ES         localparam: fraction width
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input word valid
//  in_ready   out  1       decoder can accept a word this cycle
//  in_posit   in   N       raw posit word
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       decoded result valid
//  out_ready  in   1       consumer accepts the result this cycle
//  out_sign   out  1       sign bit of in_posit
//  out_regime out  RS      regime k as signed two's complement
//  out_expo   out  ES      exponent; zero-padded at the LSBs when truncated
//  out_frac   out  FS      fraction without the hidden bit, MSB-aligned, zero-padded at the LSBs
//  out_zero   out  1       in_posit was all zeros
//  out_nar    out  1       in_posit was NaR (1 followed by all zeros)
//  out_tag    out  TAG_W   tag accepted together with the word
// BEHAVIOUR
//  - Transfers: an input transfer happens when in_valid & in_ready at a clock edge; an
//    output transfer happens when out_valid & out_ready.
//  - Stage order:
//    S1: register word, tag, sign; if sign=1, store the two's complement of bits [N-2:0].
//    S2: register the run length m of bits equal to bit N-2 (MSB first, limit N-1).
//        Register the regime polarity and the zero/NaR flags.
//    S3: k = m-1 if the run bit is 1, else k = -m. Left-shift the body by m+1 (drops the
//        run and its terminator). Take the top ES bits as the exponent and the next FS bits
//        as the fraction; bits shifted past the word read as 0.
//  - Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high.
//    Throughput: 1 word/cycle.
//  - Backpressure:
//    - Stage i loads when it is empty or stage i+1 loads in the same cycle. Stage 3 may
//      load only when it is empty or an output transfer occurs.
//    - in_ready = rst ? 0 : (S1 empty | S1 loads into S2). Bubbles collapse.
//    - At most 3 words are in flight; no word is ever dropped or duplicated.
//    - While out_valid=1 and out_ready=0, every out_* port holds stable.
//  - Terminator-less run (m = N-1): k = N-2 for a run of ones, k = -(N-1) for a run of
//    zeros. Exponent and fraction are 0.
//  - Special cases, decided in S2 from the raw word:
//    - Zero: out_zero=1, all other data fields 0.
//    - NaR: out_nar=1, out_sign=1, all other data fields 0.
//    - out_zero and out_nar are never both 1.
//  - Reset:
//    - All stage valid bits clear on the first edge with rst=1, so out_valid=0.
//    - All out_* data ports read 0 until the first result.
//    - A reset mid-operation discards every in-flight word with no output.
//  - A simultaneous input transfer and output transfer with all stages full is legal;
//    the pipeline advances and stays full.
// TESTING (N=32, ES=2, FS=27)
//  1) 0x40000000 -> sign=0, k=0, expo=0, frac=0, 3 cycles after accept.
//     0x48000000 -> k=0, expo=1. 0x60000000 -> k=1, expo=0.
//  2) 0xC0000000 -> sign=1, k=0, expo=0, frac=0 (value -1).
//     0xB8000000 -> sign=1, k=0, expo=1, frac=0 (value -2).
//  3) 0x7FFFFFFF -> k=30, expo=0, frac=0. 0x00000001 -> k=-30, expo=0, frac=0.
//     0x00000000 -> zero=1. 0x80000000 -> nar=1, sign=1.
//  4) 0x4C000000 (k=0, exp=1, frac MSB=1) -> frac=27'h4000000.
//  5) Set out_ready=0 and push 5 words with distinct tags -> in_ready drops after the 3rd
//     accept. Then set out_ready=1 -> 5 results appear in order, tags match, outputs stay
//     stable while stalled.
//  6) Assert rst for 1 cycle with 3 words in flight -> out_valid=0 the next cycle and none
//     of the 3 words ever appear. The next word accepted decodes correctly after 3 cycles.

Source files
------------

// File: rtl/posit_decoder_pipe.sv
// Three-stage pipelined posit<N,ES> field decoder with valid/ready flow control.
// Splits a raw posit into sign, signed regime k, exponent and fraction, and flags zero/NaR.
module posit_decoder_pipe #(
    parameter int N     = 32,
    parameter int ES    = 2,
    parameter int TAG_W = 4,
    localparam int RS   = $clog2(N) + 1,
    localparam int FS   = N - 3 - ES,
    localparam int EW   = (ES > 0) ? ES : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_posit,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic signed [RS-1:0] out_regime,
    output logic [EW-1:0]        out_expo,
    output logic [FS-1:0]        out_frac,
    output logic                 out_zero,
    output logic                 out_nar,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int BW = N - 1;   // body: everything below the sign bit
    localparam int RW = BW - 2;  // body bits left after the shortest run and its terminator

    function automatic logic [BW-1:0] twos_neg(input logic [BW-1:0] x);
        return ~x + {{(BW-1){1'b0}}, 1'b1};
    endfunction

    // Length of the leading run of bits equal to the body MSB, saturating at BW.
    function automatic logic [RS-1:0] run_len(input logic [BW-1:0] b);
        logic [RS-1:0] m;
        logic          done;
        m    = RS'(BW);
        done = 1'b0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (!done && (b[i] != b[BW-1])) begin
                m    = RS'(BW - 1 - i);
                done = 1'b1;
            end
        end
        return m;
    endfunction

    logic vld_p1, vld_p2, vld_p3;
    logic ld_p1, ld_p2, ld_p3, out_xfer;

    always_comb begin
        out_xfer = vld_p3 & out_ready;
        ld_p3    = vld_p2 & (~vld_p3 | out_xfer);
        ld_p2    = vld_p1 & (~vld_p2 | ld_p3);
        in_ready = ~rst & (~vld_p1 | ld_p2);
        ld_p1    = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p1 <= ld_p1 | (vld_p1 & ~ld_p2);
            vld_p2 <= ld_p2 | (vld_p2 & ~ld_p3);
            vld_p3 <= ld_p3 | (vld_p3 & ~out_xfer);
        end
    end

    // ---- Stage 1: capture word, negate body of negative posits
    logic [N-1:0]     word_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             sign_p1;
    logic [BW-1:0]    body_p1;

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            word_p1 <= in_posit;
            tag_p1  <= in_tag;
            sign_p1 <= in_posit[N-1];
            body_p1 <= in_posit[N-1] ? twos_neg(in_posit[N-2:0]) : in_posit[N-2:0];
        end
    end

    // ---- Stage 2: regime run length, polarity and special-value flags
    logic             zero_c, nar_c;
    logic [TAG_W-1:0] tag_p2;
    logic             sign_p2, pol_p2, zero_p2, nar_p2;
    logic [RS-1:0]    m_p2;
    logic [RW-1:0]    rest_p2;

    always_comb begin
        zero_c = (word_p1 == '0);
        nar_c  = (word_p1 == {1'b1, {BW{1'b0}}});
    end

    always_ff @(posedge clk) begin
        if (ld_p2) begin
            tag_p2  <= tag_p1;
            sign_p2 <= sign_p1;
            pol_p2  <= body_p1[BW-1];
            m_p2    <= run_len(body_p1);
            rest_p2 <= body_p1[RW-1:0];
            zero_p2 <= zero_c;
            nar_p2  <= nar_c;
        end
    end

    // ---- Stage 3: regime value, exponent/fraction extraction
    logic [RW-1:0]         sh_c;
    logic [EW-1:0]         expo_raw;
    logic signed [RS-1:0]  regime_c;
    logic [EW-1:0]         expo_c;
    logic [FS-1:0]         frac_c;

    // rest_p2 already excludes one run bit and one terminator, so only m-1 more remain.
    assign sh_c = rest_p2 << (m_p2 - RS'(1));

    if (ES > 0) begin : g_expo
        assign expo_raw = sh_c[RW-1 -: EW];
    end else begin : g_no_expo
        assign expo_raw = '0;
    end

    always_comb begin
        regime_c = pol_p2 ? $signed(m_p2 - RS'(1)) : -$signed(m_p2);
        expo_c   = expo_raw;
        frac_c   = sh_c[FS-1:0];
        if (zero_p2 || nar_p2) begin
            regime_c = '0;
            expo_c   = '0;
            frac_c   = '0;
        end
    end

    logic [TAG_W-1:0]     tag_p3;
    logic                 sign_p3, zero_p3, nar_p3;
    logic signed [RS-1:0] regime_p3;
    logic [EW-1:0]        expo_p3;
    logic [FS-1:0]        frac_p3;

    always_ff @(posedge clk) begin
        if (ld_p3) begin
            tag_p3    <= tag_p2;
            sign_p3   <= sign_p2;
            regime_p3 <= regime_c;
            expo_p3   <= expo_c;
            frac_p3   <= frac_c;
            zero_p3   <= zero_p2;
            nar_p3    <= nar_p2;
        end
    end

    // Data ports are masked by valid so they read 0 before any result exists.
    always_comb begin
        out_valid  = vld_p3;
        out_sign   = vld_p3 & sign_p3;
        out_regime = vld_p3 ? regime_p3 : '0;
        out_expo   = vld_p3 ? expo_p3 : '0;
        out_frac   = vld_p3 ? frac_p3 : '0;
        out_zero   = vld_p3 & zero_p3;
        out_nar    = vld_p3 & nar_p3;
        out_tag    = vld_p3 ? tag_p3 : '0;
    end

endmodule
